// File: rtl/if_prefetch.sv
// Instruction prefetch unit: streams sequential words from the AZPR bus into a
// small {pc, insn} queue and presents the queue head to the ID stage.
module if_prefetch #(
  parameter int                 ADDR_W   = 30,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [DATA_W-1:0]            i_bus_rd_data,
  input  logic                         i_bus_rdy_,
  input  logic                         i_bus_grnt_,
  output logic                         o_bus_req_,
  output logic [ADDR_W-1:0]            o_bus_addr,
  output logic                         o_bus_as_,
  output logic                         o_bus_rw,
  input  logic                         i_stall,
  input  logic                         i_flush,
  input  logic [ADDR_W-1:0]            i_new_pc,
  input  logic                         i_br_taken,
  input  logic [ADDR_W-1:0]            i_br_addr,
  output logic [ADDR_W-1:0]            o_if_pc,
  output logic [DATA_W-1:0]            o_if_insn,
  output logic                         o_if_en,
  output logic                         o_busy,
  output logic [$clog2(DEPTH+1)-1:0]   o_fill_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACCESS,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  w_fetch_pc_next;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_next;

  logic [ADDR_W-1:0]  r_q_pc   [DEPTH];
  logic [DATA_W-1:0]  r_q_insn [DEPTH];

  logic               w_redir;
  logic [ADDR_W-1:0]  w_target;
  logic               w_in_xfer;
  logic               w_push;
  logic               w_pop;

  // flush outranks a branch taken in the same cycle
  assign w_redir   = i_flush | i_br_taken;
  assign w_target  = i_flush ? i_new_pc : i_br_addr;
  assign w_in_xfer = (r_state == S_ACCESS) || (r_state == S_WAIT);
  assign w_push    = w_in_xfer && !i_bus_rdy_ && !w_redir;
  assign w_pop     = o_if_en && !i_stall && !w_redir;

  always_comb begin
    w_count_next = r_count;
    if (w_redir) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    if (w_redir) begin
      w_fetch_pc_next = w_target;
    end else if (w_push) begin
      w_fetch_pc_next = r_fetch_pc + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_redir && (r_count < DEPTH_C)) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (!w_redir && !i_bus_grnt_) w_state_next = S_ACCESS;
      end
      S_ACCESS, S_WAIT: begin
        // an in-flight word after a redirect is stale and must be drained
        if (i_bus_rdy_) begin
          w_state_next = w_redir ? S_DISCARD : S_WAIT;
        end else if (!w_redir && (w_count_next < DEPTH_C) && !i_bus_grnt_) begin
          w_state_next = S_ACCESS;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (!i_bus_rdy_) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_count    <= w_count_next;
      if (w_redir) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // queue storage needs no reset: the head is gated by o_if_en
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      r_q_insn[r_wr_ptr] <= i_bus_rd_data;
    end
  end

  assign o_if_en      = (r_count != '0);
  assign o_if_pc      = o_if_en ? r_q_pc[r_rd_ptr]   : '0;
  assign o_if_insn    = o_if_en ? r_q_insn[r_rd_ptr] : '0;
  assign o_fill_level = r_count;
  assign o_busy       = (r_count == '0) && (w_in_xfer || (r_state == S_DISCARD));

  assign o_bus_req_   = (r_state == S_IDLE);
  assign o_bus_as_    = (r_state != S_ACCESS);
  assign o_bus_addr   = w_in_xfer ? r_fetch_pc : '0;
  assign o_bus_rw     = 1'b1;

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-prefetch unit, the successor to the single-entry IF fetch path. It fetches sequential instruction words over the AZPR master bus into a DEPTH-entry queue of {pc, insn} pairs and presents the queue head to the ID stage. It sits between the IF-side bus master port and the IF/ID pipeline boundary, and accepts stall, flush and branch redirects from the pipeline control.

## Interface
- ADDR_W, 30, word-address width.
- DATA_W, 32, instruction word width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch word address after reset.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_rd_data  in  DATA_W  read data, valid when bus_rdy_=0.
- bus_rdy_  in  1  ready, active low.
- bus_grnt_  in  1  bus grant, active low.
- bus_req_  out  1  bus request, active low.
- bus_addr  out  ADDR_W  fetch word address.
- bus_as_  out  1  address strobe, active low.
- bus_rw  out  1  constant 1 (READ).
- stall  in  1  ID not accepting; head is held.
- flush  in  1  redirect to new_pc; has priority over br_taken.
- new_pc  in  ADDR_W  flush target.
- br_taken  in  1  redirect to br_addr.
- br_addr  in  ADDR_W  branch target.
- if_pc  out  ADDR_W  PC of head entry; 0 when if_en=0.
- if_insn  out  DATA_W  head instruction; 0 (NOP) when if_en=0.
- if_en  out  1  head entry valid.
- busy  out  1  queue empty and a fetch or discard is in flight.
- fill_level  out  $clog2(DEPTH+1)  current entry count.

## Operation
- State: fetch_pc (ADDR_W), queue (rd/wr pointers of $clog2(DEPTH) bits, wrap modulo DEPTH), count 0..DEPTH, FSM {IDLE, REQ, ACCESS, WAIT, DISCARD}.
- Reset: fetch_pc=RESET_PC; count=0; FSM=IDLE; bus_req_=1, bus_as_=1, bus_addr=0, bus_rw=1; if_en=0, if_pc=0, if_insn=0, busy=0, fill_level=0.
- Bus outputs are decoded from the registered state: bus_req_=0 in REQ/ACCESS/WAIT/DISCARD; bus_as_=0 only in ACCESS; bus_addr=fetch_pc in ACCESS/WAIT, else 0.
- Pop occurs when if_en=1 and stall=0. Push occurs when a fetch captures data with bus_rdy_=0 in ACCESS or WAIT and no redirect is active that cycle.
- Simultaneous push and pop leave count unchanged. A push at count=DEPTH never occurs.
- FSM:
  - IDLE→REQ when count<DEPTH.
  - REQ→ACCESS when bus_grnt_=0.
  - ACCESS/WAIT with bus_rdy_=1: ACCESS→WAIT, WAIT stays.
  - ACCESS/WAIT with bus_rdy_=0: push, fetch_pc+=1 (wraps modulo 2^ADDR_W). Next state is ACCESS if the post-cycle count<DEPTH and bus_grnt_=0; otherwise IDLE.
- Redirect (flush or br_taken):
  - Queue cleared (count=0, pointers reset); fetch_pc=new_pc if flush, else br_addr.
  - if_en=0 on the next cycle. Any pop in the redirect cycle is ignored.
  - In IDLE/REQ: the state is kept and the next fetch uses the new PC.
  - In ACCESS/WAIT with bus_rdy_=0: data is discarded and the FSM goes to IDLE.
  - In ACCESS/WAIT with bus_rdy_=1: the FSM goes to DISCARD. DISCARD holds until bus_rdy_=0, drops that data, then goes to IDLE. Redirects arriving during DISCARD only update fetch_pc.
- busy=1 when count=0 and FSM∈{ACCESS, WAIT, DISCARD}.

## Timing
- Zero-wait bus (grnt_=0, rdy_=0 always), reset released before edge 0:
  - Edge 0: IDLE→REQ.
  - Edge 1: →ACCESS.
  - Edge 2: capture RESET_PC.
  - From edge 2: if_en=1, if_pc=RESET_PC.
- Streaming rate is one word per cycle while room remains. Capture-to-if_en latency is 1 cycle.
- A stalled head holds if_pc and if_insn stable.
- A redirect in cycle n gives if_en=0 in cycle n+1. The first new entry appears no earlier than 3 cycles after the FSM re-enters IDLE/REQ with the grant available.
- Reset asserted mid-transaction forces all reset values immediately; the bus transaction is abandoned.

## Test plan
- Zero-wait bus, RESET_PC=0x100, stall=0 → if_pc sequence 0x100, 0x101, 0x102… from cycle 3, one per cycle, with insn matching memory.
- stall=1 held, DEPTH=4 → fill_level reaches 4, bus_req_ returns to 1, if_pc stays at 0x100; release stall → fetching resumes at 0x104.
- bus_rdy_ delayed 3 cycles per access → FSM passes through WAIT; busy=1 while empty; entries are correct with no duplicates.
- br_taken with br_addr=0x200 while in WAIT (rdy_=1) → DISCARD; the late data is dropped; the next if_pc=0x200.
- flush (new_pc=0x40) and br_taken (0x80) in the same cycle, with a pop in that cycle → queue empties, the next valid if_pc=0x40, and fill_level is never negative.
- Reset asserted during ACCESS → bus_as_=1 and bus_req_=1 immediately; after release, fetching restarts at RESET_PC.
